// File: rtl/regbank_port_arbiter_if.sv
// Bundle of the requester handshake and register-bank control signals that
// pass through the arbiter. The requester side uses the master modport and
// the arbiter uses the slave modport.
interface regbank_port_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int AW       = 3,
    parameter int DW       = 32
);
    // Requester side: one op per requester, packed per requester index
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    rw;
    logic [NUM_REQ*AW-1:0] addr;
    logic [NUM_REQ*DW-1:0] wdata;

    // Grant feedback to the requesters
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    bsel;

    // Register-bank controls
    logic [NUM_REGS-1:0]   wr_en;
    logic [NUM_REGS-1:0]   rd_enA;
    logic [NUM_REGS-1:0]   rd_enB;
    logic [DW-1:0]         D;

    modport master (
        output req, rw, addr, wdata,
        input  gnt, bsel, wr_en, rd_enA, rd_enB, D
    );

    modport slave (
        input  req, rw, addr, wdata,
        output gnt, bsel, wr_en, rd_enA, rd_enB, D
    );
endinterface

// File: rtl/regbank_port_arbiter.sv
// Round-robin arbiter sharing one register bank (one write port, two read
// buses a/b) among NUM_REQ requesters. Each cycle it grants at most one write
// and two reads, and registers the one-hot enables, D and per-requester grant.
module regbank_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int AW       = 3,
    parameter int DW       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    regbank_port_arbiter_if.slave  bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registered state
    logic [PW-1:0]       ptr_q,    ptr_d;
    logic [NUM_REQ-1:0]  gnt_q,    gnt_d;
    logic [NUM_REQ-1:0]  bsel_q,   bsel_d;
    logic [NUM_REGS-1:0] wr_en_q,  wr_en_d;
    logic [NUM_REGS-1:0] rd_enA_q, rd_enA_d;
    logic [NUM_REGS-1:0] rd_enB_q, rd_enB_d;
    logic [DW-1:0]       D_q,      D_d;

    // Unpacked per-requester views of the packed address and data buses
    logic [AW-1:0] addr_a  [NUM_REQ];
    logic [DW-1:0] wdata_a [NUM_REQ];

    // Address to one-hot enable; addresses past the bank decode to all-zero
    function automatic logic [NUM_REGS-1:0] decode(input logic [AW-1:0] a);
        logic [NUM_REGS-1:0] dec;
        dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            dec[r] = (a == AW'(r));
        end
        return dec;
    endfunction

    // Pointer value that follows requester i, wrapping at NUM_REQ
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        int n;
        n = int'(i) + 1;
        if (n >= NUM_REQ) begin
            n = 0;
        end
        return PW'(n);
    endfunction

    // Split the packed requester buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = bus.addr[i*AW +: AW];
            wdata_a[i] = bus.wdata[i*DW +: DW];
        end
    end

    // Round-robin scan from ptr: first writer takes the write port, first two
    // readers take bus a then bus b; the pointer follows the last winner
    always_comb begin
        logic          w_found;
        logic          a_found;
        logic          b_found;
        int            pos;
        logic [PW-1:0] idx;

        gnt_d    = '0;
        bsel_d   = '0;
        wr_en_d  = '0;
        rd_enA_d = '0;
        rd_enB_d = '0;
        D_d      = D_q;
        ptr_d    = ptr_q;
        w_found  = 1'b0;
        a_found  = 1'b0;
        b_found  = 1'b0;
        pos      = 0;
        idx      = '0;

        for (int j = 0; j < NUM_REQ; j++) begin
            pos = int'(ptr_q) + j;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = PW'(pos);
            if (bus.req[idx]) begin
                if (bus.rw[idx]) begin
                    if (!w_found) begin
                        w_found    = 1'b1;
                        gnt_d[idx] = 1'b1;
                        wr_en_d    = decode(addr_a[idx]);
                        D_d        = wdata_a[idx];
                        ptr_d      = next_ptr(idx);
                    end
                end else if (!a_found) begin
                    a_found    = 1'b1;
                    gnt_d[idx] = 1'b1;
                    rd_enA_d   = decode(addr_a[idx]);
                    ptr_d      = next_ptr(idx);
                end else if (!b_found) begin
                    b_found     = 1'b1;
                    gnt_d[idx]  = 1'b1;
                    bsel_d[idx] = 1'b1;
                    rd_enB_d    = decode(addr_a[idx]);
                    ptr_d       = next_ptr(idx);
                end
            end
        end
    end

    // Grant/enable registers; async reset drops every enable at once so an
    // in-flight write never reaches the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            bsel_q   <= '0;
            wr_en_q  <= '0;
            rd_enA_q <= '0;
            rd_enB_q <= '0;
            D_q      <= '0;
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            bsel_q   <= bsel_d;
            wr_en_q  <= wr_en_d;
            rd_enA_q <= rd_enA_d;
            rd_enB_q <= rd_enB_d;
            D_q      <= D_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.bsel   = bsel_q;
    assign bus.wr_en  = wr_en_q;
    assign bus.rd_enA = rd_enA_q;
    assign bus.rd_enB = rd_enB_q;
    assign bus.D      = D_q;

    // At most one register may drive each bus or take the write
    a_wr_en_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(wr_en_q));
    a_rd_enA_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rd_enA_q));
    a_rd_enB_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(rd_enB_q));

endmodule

// File: doc/regbank_port_arbiter.md
Name: regbank_port_arbiter

Overview:
- Shares one bank of NUM_REGS reg32_tworead registers among NUM_REQ requesters.
- The bank has one write port (shared D bus plus per-register wr_en) and two tristate read buses, a and b (per-register rd_enA and rd_enB).
- Each cycle the block grants at most one write and at most two reads, using round-robin priority.
- It drives the one-hot enables and the D bus, and tells each read requester which bus carries its data.

Parameters:
- NUM_REQ, 4, number of requesters.
- NUM_REGS, 8, number of registers in the bank.
- AW, 3, register address width (ceil(log2(NUM_REGS))).
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held until the matching gnt bit is seen.
- rw  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
- addr  input  NUM_REQ*AW  packed register addresses; requester i uses bits [i*AW +: AW].
- wdata  input  NUM_REQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- gnt  output  NUM_REQ  registered one-cycle grant per requester.
- bsel  output  NUM_REQ  valid with gnt on a read grant: 0 = data on bus a, 1 = data on bus b.
- wr_en  output  NUM_REGS  one-hot (or zero) write enable to the bank.
- rd_enA  output  NUM_REGS  one-hot (or zero) enable onto bus a.
- rd_enB  output  NUM_REGS  one-hot (or zero) enable onto bus b.
- D  output  DW  write data to the bank.

Behaviour:
- Reset (async, rst=1): gnt, bsel, wr_en, rd_enA, rd_enB, D and the round-robin pointer ptr all go to 0 immediately.
  - Asserting rst mid-grant drops all enables in the same cycle; an in-flight write is not committed.
  - After rst deasserts, requests still held are re-arbitrated normally.
- Arbitration at each posedge:
  - Scan requesters in order ptr, ptr+1, ..., ptr+NUM_REQ-1 (mod NUM_REQ), considering only those with req=1.
  - The first requester with rw=1 wins the write port.
  - The first requester with rw=0 wins bus a; the second wins bus b.
  - Every other requester waits; losers see no state change.
- Grant outputs are registered. For a request sampled at posedge k, during cycle k..k+1:
  - gnt[i]=1 for every winner.
  - Write winner: wr_en[addr_i]=1 and D=wdata_i. The bank commits the write at posedge k+1.
  - Bus-a read winner: rd_enA[addr_i]=1, bsel[i]=0. Bus-b read winner: rd_enB[addr_i]=1, bsel[i]=1.
  - The requester samples a or b at posedge k+1.
- Latency is one cycle from the sampling edge to the enables; sustained throughput is 1 write + 2 reads per cycle.
- Pointer update:
  - ptr <= (scan position of the last granted requester) + 1, mod NUM_REQ.
  - ptr is unchanged when nothing is granted.
  - Guarantee: a requester holding req is granted within NUM_REQ cycles.
- Requester handshake:
  - req, rw, addr and wdata stay stable while req=1 and ungranted.
  - On seeing gnt, the requester drops req before the next posedge, or presents a new op for back-to-back service.
- Idle values:
  - With no grant, all enables and gnt are 0; D holds its last value. Both buses float, since the bank drives Z.
  - When no read is granted, bsel=0.
- Boundary conditions:
  - Two reads of the same register in one cycle: both are granted, one on a and one on b.
  - Read and write of the same register in one grant cycle: the read returns the old value; the new value is visible from the next grant.
  - addr >= NUM_REGS: the request is granted, but no enable bit is asserted. A write is dropped; a read sees Z.
  - wr_en, rd_enA and rd_enB each have at most one bit set; checked by assertion.

Test Plan:
1. Pulse rst=1 mid-cycle while a grant is active (gnt=0001, wr_en=00001000) -> gnt, wr_en, rd_enA, rd_enB and D read 0 within 1 ns; after release, the held req0 is re-granted on the next posedge.
2. Single write, then read:
   - req0 rw=1 addr=3 wdata=A5A5A5A5 -> next cycle gnt=0001, wr_en=00001000, D=A5A5A5A5.
   - Then req1 rw=0 addr=3 -> gnt=0010, rd_enA=00001000, bsel[1]=0, a=A5A5A5A5, b=Z.
3. Three simultaneous reads, ptr=0: req0/1/2 read addr 1/2/5 ->
   - Cycle 1: gnt=0011, rd_enA=00000010, rd_enB=00000100, bsel=0010.
   - Cycle 2 (only req2 still held): gnt=0100, rd_enA=00100000; ptr becomes 3.
4. Write contention: req1 (addr2, FFFFFFFF) and req3 (addr4, 00000000) both write, ptr=0 -> req1 is granted first (wr_en=00000100), then req3 (wr_en=00010000); never two wr_en bits in one cycle.
5. Same-register read-during-write: reg6=0; req0 writes 12345678 to reg6 while req1 reads reg6 -> in the same grant cycle a=00000000; a re-read by req1 the next cycle returns 12345678.
6. Fairness: all four requesters hold continuous write requests -> gnt sequence is 0001, 0010, 0100, 1000, 0001; no requester waits more than 4 cycles.
